// File: rtl/lsu_pkg.sv
// Shared constants, FSM state encoding and request payload types for the load/store unit.
package lsu_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned WADDR_W = 30;
   localparam int unsigned STRB_W  = 4;
   localparam int unsigned CAUSE_W = 4;
   localparam int unsigned F3_W    = 3;

   localparam logic [F3_W-1:0] F3_B  = 3'd0;
   localparam logic [F3_W-1:0] F3_H  = 3'd1;
   localparam logic [F3_W-1:0] F3_W_ = 3'd2;
   localparam logic [F3_W-1:0] F3_BU = 3'd4;
   localparam logic [F3_W-1:0] F3_HU = 3'd5;

   localparam logic [CAUSE_W-1:0] CAUSE_NONE        = 4'd0;
   localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL     = 4'd2;
   localparam logic [CAUSE_W-1:0] CAUSE_LD_MISALIGN = 4'd4;
   localparam logic [CAUSE_W-1:0] CAUSE_LD_ACCESS   = 4'd5;
   localparam logic [CAUSE_W-1:0] CAUSE_ST_MISALIGN = 4'd6;
   localparam logic [CAUSE_W-1:0] CAUSE_ST_ACCESS   = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } lsu_state_e;

   typedef struct packed {
      logic            write;
      logic [F3_W-1:0] funct3;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } lsu_req_t;

   // Request context still needed after the address and data are on the bus
   typedef struct packed {
      logic            write;
      logic [F3_W-1:0] funct3;
      logic [1:0]      byte_off;
   } lsu_ctx_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store steering and strobes, load extraction/extension,
// misalignment and illegal-width detection.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [F3_W-1:0]   funct3,
   input  logic              write,
   input  logic [1:0]        byte_off,
   input  logic [XLEN-1:0]   wdata,
   input  logic [XLEN-1:0]   rword,
   output logic [XLEN-1:0]   wdata_lanes_c,
   output logic [STRB_W-1:0] strobe_c,
   output logic [XLEN-1:0]   rdata_ext_c,
   output logic              misaligned_c,
   output logic              illegal_c
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   // Size decode drives steering, strobes and alignment
   always_comb begin
      wdata_lanes_c = wdata;
      strobe_c      = '0;
      misaligned_c  = 1'b0;
      illegal_c     = 1'b0;
      case (funct3[1:0])
         2'd0: begin
            wdata_lanes_c = {4{wdata[7:0]}};
            strobe_c      = 4'b0001 << byte_off;
         end
         2'd1: begin
            wdata_lanes_c = {2{wdata[15:0]}};
            strobe_c      = 4'b0011 << byte_off;
            misaligned_c  = byte_off[0];
         end
         2'd2: begin
            strobe_c     = 4'b1111;
            misaligned_c = |byte_off;
         end
         default: illegal_c = 1'b1;
      endcase
      // Unsigned variants exist only for byte/half loads
      if (funct3[2] && (write || funct3[1:0] == 2'd2))
         illegal_c = 1'b1;
   end

   always_comb begin
      case (byte_off)
         2'd0:    rbyte = rword[7:0];
         2'd1:    rbyte = rword[15:8];
         2'd2:    rbyte = rword[23:16];
         default: rbyte = rword[31:24];
      endcase
      rhalf = byte_off[1] ? rword[31:16] : rword[15:0];
   end

   always_comb begin
      case (funct3)
         F3_B:    rdata_ext_c = {{24{rbyte[7]}}, rbyte};
         F3_BU:   rdata_ext_c = {24'd0, rbyte};
         F3_H:    rdata_ext_c = {{16{rhalf[15]}}, rhalf};
         F3_HU:   rdata_ext_c = {16'd0, rhalf};
         F3_W_:   rdata_ext_c = rword;
         default: rdata_ext_c = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory bus initiator: one load/store at a time, IDLE -> ACCESS -> RESP,
// with early faults going straight to RESP.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [F3_W-1:0]     req_funct3,
   input  logic [XLEN-1:0]     req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   output logic                resp_valid,
   output logic [XLEN-1:0]     resp_rdata,
   output logic                resp_fault,
   output logic [CAUSE_W-1:0]  resp_cause,
   output logic [WADDR_W-1:0]  mem_address,
   output logic [STRB_W-1:0]   mem_write_enable,
   output logic [XLEN-1:0]     mem_data_out,
   input  logic [XLEN-1:0]     mem_data_in,
   input  logic                mem_read_capable,
   input  logic                mem_write_capable
);

   lsu_state_e          state_q, state_d;
   lsu_ctx_t            ctx_q, ctx_d;
   lsu_req_t            req_c;
   logic [WADDR_W-1:0]  addr_q, addr_d;
   logic [STRB_W-1:0]   we_q, we_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic                valid_q, valid_d;
   logic [XLEN-1:0]     rdata_q, rdata_d;
   logic                fault_q, fault_d;
   logic [CAUSE_W-1:0]  cause_q, cause_d;

   logic                al_write;
   logic [F3_W-1:0]     al_funct3;
   logic [1:0]          al_off;
   logic [XLEN-1:0]     lanes_c, ext_c;
   logic [STRB_W-1:0]   strobe_c;
   logic                misaligned_c, illegal_c;

   assign req_c = '{write: req_write, funct3: req_funct3, addr: req_addr, wdata: req_wdata};

   // Lane logic sees the incoming request in IDLE and the latched one afterwards
   always_comb begin
      if (state_q == ST_IDLE) begin
         al_write  = req_c.write;
         al_funct3 = req_c.funct3;
         al_off    = req_c.addr[1:0];
      end else begin
         al_write  = ctx_q.write;
         al_funct3 = ctx_q.funct3;
         al_off    = ctx_q.byte_off;
      end
   end

   lsu_align u_align (
      .funct3        (al_funct3),
      .write         (al_write),
      .byte_off      (al_off),
      .wdata         (req_c.wdata),
      .rword         (mem_data_in),
      .wdata_lanes_c (lanes_c),
      .strobe_c      (strobe_c),
      .rdata_ext_c   (ext_c),
      .misaligned_c  (misaligned_c),
      .illegal_c     (illegal_c)
   );

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      ctx_d   = ctx_q;
      addr_d  = addr_q;
      we_d    = '0;
      wdata_d = wdata_q;
      valid_d = 1'b0;
      rdata_d = rdata_q;
      fault_d = fault_q;
      cause_d = cause_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               ctx_d   = '{write: req_c.write, funct3: req_c.funct3, byte_off: req_c.addr[1:0]};
               rdata_d = '0;
               if (illegal_c || misaligned_c) begin
                  state_d = ST_RESP;
                  valid_d = 1'b1;
                  fault_d = 1'b1;
                  if (illegal_c)
                     cause_d = CAUSE_ILLEGAL;
                  else
                     cause_d = req_c.write ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
               end else begin
                  state_d = ST_ACCESS;
                  addr_d  = req_c.addr[XLEN-1:2];
                  fault_d = 1'b0;
                  cause_d = CAUSE_NONE;
                  if (req_c.write) begin
                     we_d    = strobe_c;
                     wdata_d = lanes_c;
                  end
               end
            end
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            valid_d = 1'b1;
            if (ctx_q.write) begin
               if (!mem_write_capable) begin
                  fault_d = 1'b1;
                  cause_d = CAUSE_ST_ACCESS;
               end
            end else if (mem_read_capable) begin
               rdata_d = ext_c;
            end else begin
               fault_d = 1'b1;
               cause_d = CAUSE_LD_ACCESS;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ctx_q   <= '0;
         addr_q  <= '0;
         we_q    <= '0;
         wdata_q <= '0;
         valid_q <= 1'b0;
         rdata_q <= '0;
         fault_q <= 1'b0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         ctx_q   <= ctx_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
      end
   end

   // Armed strobes are gated by the write capability of the address on the bus
   assign mem_write_enable = we_q & {STRB_W{mem_write_capable}};
   assign mem_address      = addr_q;
   assign mem_data_out     = wdata_q;
   assign resp_valid       = valid_q;
   assign resp_rdata       = rdata_q;
   assign resp_fault       = fault_q;
   assign resp_cause       = cause_q;
   assign req_ready        = (state_q == ST_IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: memory device model, byte-array reference, directed then random requests.
`timescale 1ns/1ps
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [3:0]  resp_cause;
   logic [29:0] mem_address;
   logic [3:0]  mem_write_enable;
   logic [31:0] mem_data_out;
   logic [31:0] mem_data_in;
   logic        mem_read_capable;
   logic        mem_write_capable;

   load_store_unit dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .req_funct3        (req_funct3),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .resp_valid        (resp_valid),
      .resp_rdata        (resp_rdata),
      .resp_fault        (resp_fault),
      .resp_cause        (resp_cause),
      .mem_address       (mem_address),
      .mem_write_enable  (mem_write_enable),
      .mem_data_out      (mem_data_out),
      .mem_data_in       (mem_data_in),
      .mem_read_capable  (mem_read_capable),
      .mem_write_capable (mem_write_capable)
   );

   always #5 clk = ~clk;

   // Memory map: below 0x1000 read-only, page 0xFFFF_xxxx write-only, all else read/write
   function automatic logic rd_cap(input logic [31:0] a);
      return a[31:16] != 16'hFFFF;
   endfunction
   function automatic logic wr_cap(input logic [31:0] a);
      return a >= 32'h0000_1000;
   endfunction
   function automatic logic [31:0] init_word(input int i);
      return 32'(i) * 32'h9E37_79B1 + 32'h1234_5677;
   endfunction

   logic [31:0] dev_mem [256];
   logic        mem_init;
   logic [7:0]  ref_mem [1024];

   always_comb begin
      mem_data_in       = dev_mem[mem_address[7:0]];
      mem_read_capable  = rd_cap({mem_address, 2'b00});
      mem_write_capable = wr_cap({mem_address, 2'b00});
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) dev_mem[i] <= init_word(i);
      end else begin
         for (int i = 0; i < 4; i++)
            if (mem_write_enable[i]) dev_mem[mem_address[7:0]][8*i +: 8] <= mem_data_out[8*i +: 8];
      end
   end

   int checks = 0;
   int failures = 0;
   logic [29:0] exp_addr;
   logic [31:0] exp_dout;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request and check every cycle of it against the reference rules
   task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input string tag,
                         output logic [31:0] o_rdata, output logic [3:0] o_cause,
                         output logic [3:0] o_strb);
      logic        legal, early, commit, xfault;
      logic [3:0]  xcause, xstrb;
      logic [31:0] xrdata, xdout;
      int unsigned sz, o;
      legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      sz    = 1 << f3[1:0];
      early = 1'b0; commit = 1'b0; xfault = 1'b0; xcause = 4'd0; xstrb = 4'd0; xrdata = 32'd0;
      xdout = exp_dout;
      o     = 32'(a[9:0]);
      if (!legal) begin
         early = 1'b1; xfault = 1'b1; xcause = 4'd2;
      end else if ((a % sz) != 0) begin
         early = 1'b1; xfault = 1'b1; xcause = w ? 4'd6 : 4'd4;
      end else if (w) begin
         xdout = (sz == 1) ? {4{d[7:0]}} : (sz == 2) ? {2{d[15:0]}} : d;
         if (wr_cap(a)) begin
            commit = 1'b1;
            for (int i = 0; i < 4; i++) if (i >= (a % 4) && i < (a % 4) + sz) xstrb[i] = 1'b1;
         end else begin
            xfault = 1'b1; xcause = 4'd7;
         end
      end else if (!rd_cap(a)) begin
         xfault = 1'b1; xcause = 4'd5;
      end else begin
         case (f3)
            3'd0: xrdata = 32'($signed(ref_mem[o]));
            3'd4: xrdata = 32'(ref_mem[o]);
            3'd1: xrdata = 32'($signed({ref_mem[o+1], ref_mem[o]}));
            3'd5: xrdata = 32'({ref_mem[o+1], ref_mem[o]});
            default: xrdata = {ref_mem[o+3], ref_mem[o+2], ref_mem[o+1], ref_mem[o]};
         endcase
      end

      @(negedge clk);
      chk({tag, ".ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      @(negedge clk);
      o_strb = mem_write_enable;
      if (early) begin
         chk({tag, ".valid_n1"}, 32'(resp_valid), 32'd1);
         chk({tag, ".we_none"}, 32'(mem_write_enable), 32'd0);
         chk({tag, ".addr_hold"}, 32'(mem_address), 32'(exp_addr));
      end else begin
         exp_addr = a[31:2];
         exp_dout = xdout;
         chk({tag, ".valid_acc"}, 32'(resp_valid), 32'd0);
         chk({tag, ".ready_acc"}, 32'(req_ready), 32'd0);
         chk({tag, ".strobes"}, 32'(mem_write_enable), 32'(xstrb));
         chk({tag, ".addr"}, 32'(mem_address), 32'(exp_addr));
         chk({tag, ".dout"}, mem_data_out, exp_dout);
         @(negedge clk);
         chk({tag, ".valid_n2"}, 32'(resp_valid), 32'd1);
         chk({tag, ".we_resp"}, 32'(mem_write_enable), 32'd0);
      end
      chk({tag, ".fault"}, 32'(resp_fault), 32'(xfault));
      chk({tag, ".cause"}, 32'(resp_cause), 32'(xcause));
      chk({tag, ".rdata"}, resp_rdata, xrdata);
      o_rdata = resp_rdata;
      o_cause = resp_cause;
      if (commit)
         for (int i = 0; i < 4; i++) if (xstrb[i]) ref_mem[{o[9:2], 2'(i)}] = xdout[8*i +: 8];
      @(negedge clk);
      chk({tag, ".valid_pulse"}, 32'(resp_valid), 32'd0);
      chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic [3:0]  cs, sb;
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      int unsigned sel;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; mem_init = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [31:0] iw;
         iw = init_word(i);
         for (int k = 0; k < 4; k++) ref_mem[4*i+k] = iw[8*k +: 8];
      end
      exp_addr = 30'd0; exp_dout = 32'd0;
      repeat (2) @(negedge clk);
      mem_init = 1'b0;
      chk("rst.ready", 32'(req_ready), 32'd1);
      chk("rst.valid", 32'(resp_valid), 32'd0);
      chk("rst.we", 32'(mem_write_enable), 32'd0);
      chk("rst.addr", 32'(mem_address), 32'd0);
      chk("rst.dout", mem_data_out, 32'd0);
      chk("rst.rdata_fault_cause", {resp_rdata[27:0], resp_fault, 3'd0} | 32'(resp_cause), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_req(1'b1, 3'd2, 32'h8000_0010, 32'hDEAD_BEEF, "sw", rd, cs, sb);
      chk("sw.strb1111", 32'(sb), 32'hF);
      do_req(1'b0, 3'd2, 32'h8000_0010, 32'h0, "lw", rd, cs, sb);
      chk("lw.deadbeef", rd, 32'hDEAD_BEEF);
      do_req(1'b1, 3'd0, 32'h8000_0013, 32'h0000_00A5, "sb", rd, cs, sb);
      chk("sb.strb1000", 32'(sb), 32'h8);
      chk("sb.lanes", mem_data_out, 32'hA5A5_A5A5);
      do_req(1'b0, 3'd0, 32'h8000_0013, 32'h0, "lb", rd, cs, sb);
      chk("lb.sext", rd, 32'hFFFF_FFA5);
      do_req(1'b0, 3'd4, 32'h8000_0013, 32'h0, "lbu", rd, cs, sb);
      chk("lbu.zext", rd, 32'h0000_00A5);
      do_req(1'b0, 3'd1, 32'h8000_0001, 32'h0, "lh_mis", rd, cs, sb);
      chk("lh_mis.cause4", 32'(cs), 32'd4);
      do_req(1'b1, 3'd2, 32'h0000_0100, 32'h1111_2222, "sw_ro", rd, cs, sb);
      chk("sw_ro.cause7", 32'(cs), 32'd7);
      chk("sw_ro.strb0", 32'(sb), 32'd0);
      do_req(1'b1, 3'd2, 32'hFFFF_0000, 32'h3333_4444, "sw_wo", rd, cs, sb);
      chk("sw_wo.cause0", 32'(cs), 32'd0);
      chk("sw_wo.strb1111", 32'(sb), 32'hF);
      do_req(1'b0, 3'd2, 32'hFFFF_0000, 32'h0, "lw_wo", rd, cs, sb);
      chk("lw_wo.cause5", 32'(cs), 32'd5);
      chk("lw_wo.rdata0", rd, 32'd0);
      do_req(1'b0, 3'd3, 32'h8000_0020, 32'h0, "f3_ill", rd, cs, sb);
      chk("f3_ill.cause2", 32'(cs), 32'd2);
      chk("f3_ill.fault", 32'(resp_fault), 32'd1);

      // Reset in the middle of a store's ACCESS cycle
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
      req_addr = 32'h8000_0020; req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rstmid.we_before", 32'(mem_write_enable), 32'hF);
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid.we_async", 32'(mem_write_enable), 32'd0);
      chk("rstmid.ready_async", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      exp_addr = 30'd0; exp_dout = 32'd0;
      for (int i = 0; i < 3; i++) begin
         chk("rstmid.no_resp", 32'(resp_valid), 32'd0);
         chk("rstmid.ready", 32'(req_ready), 32'd1);
         @(negedge clk);
      end
      chk("rstmid.addr0", 32'(mem_address), 32'd0);
      chk("rstmid.dout0", mem_data_out, 32'd0);
      do_req(1'b0, 3'd2, 32'h8000_0020, 32'h0, "rstmid_lw", rd, cs, sb);

      // Random mix over the three regions, biased towards aligned accesses
      for (int n = 0; n < 250; n++) begin
         w   = 1'($urandom);
         sel = $urandom_range(0, 11);
         f3  = (sel < 8) ? 3'(sel) : (sel < 10 ? 3'd2 : 3'd0);
         sel = $urandom_range(0, 9);
         a   = 32'($urandom_range(0, 1023));
         if (sel == 8)      a = a | 32'h0000_0000;
         else if (sel == 9) a = a | 32'hFFFF_0000;
         else               a = a | 32'h8000_0000;
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
         do_req(w, f3, a, $urandom, "rnd", rd, cs, sb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

CPU-side initiator for the data-memory bus: accepts one load or store request at a time from the execute stage and drives the word-addressed, byte-lane-enabled memory port. It steers store data onto byte lanes, extracts and sign- or zero-extends load data, and reports misaligned, access and illegal faults using RISC-V cause codes. It sits between the core pipeline and the memory decoder, whose read data is combinational, whose writes commit on the clock edge, and which reports per-address read and write capability.

## Interface

Parameters: none.

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width/sign code (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores or faults)
- resp_fault  out  1  request faulted
- resp_cause  out  4  0 none, 2 illegal funct3, 4 load misaligned, 5 load access, 6 store misaligned, 7 store access
- mem_address  out  30  word address [31:2]
- mem_write_enable  out  4  byte-lane write strobes
- mem_data_out  out  32  lane-steered store data
- mem_data_in  in  32  read word from memory
- mem_read_capable  in  1  address is readable
- mem_write_capable  in  1  address is writable

## Operation

- States: IDLE, ACCESS, RESP.
- IDLE: accept when req_valid && req_ready and latch write, funct3, addr and wdata. Illegal funct3 or misalignment (H with addr[0]=1, W with addr[1:0]≠0) goes to RESP with a fault. Otherwise go to ACCESS.
- ACCESS, one cycle:
  - mem_address = latched addr[31:2].
  - Store: if mem_write_capable, strobes are SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111. Otherwise strobes are 0 with cause 7.
  - Load: strobes are 0. If mem_read_capable, capture extracted data. Otherwise cause 5.
  - Next state is RESP.
- RESP: resp_valid=1 for exactly one cycle with the registered rdata, fault and cause, then IDLE. No request is accepted in RESP.
- Store steering: replicate byte and halfword (SB data×4, SH data×2, SW as-is).
- Load extraction: select byte or halfword by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend.
- mem_write_enable is 0 in every state except ACCESS.
- Outside ACCESS, mem_address holds its last value. mem_data_out holds its last value at all times.

## Timing

- Accept at edge N. ACCESS during cycle N+1, where the store commits on edge N+2. resp_valid is high in cycle N+2.
- Faulted-at-accept requests show resp_valid in cycle N+1 and never enter ACCESS.
- Throughput: one request per 3 cycles, or 2 cycles for early faults.
- All outputs except req_ready are registered. req_ready = (state==IDLE).
- Reset (async, any state): state IDLE, mem_write_enable 0 immediately, mem_address 0, mem_data_out 0, resp_valid 0, resp_rdata 0, resp_fault 0, resp_cause 0.
- Reset during ACCESS aborts the write with no commit and no response.
- Capability inputs are sampled only in ACCESS and are assumed combinational from mem_address.

## Structure

- Package lsu_pkg: funct3 constants, cause-code constants, state enum.
- Sub-module lsu_align: combinational lane steering, strobe generation, load extraction and extension, misalignment and illegal detection.
- load_store_unit: FSM and registers.

## Test plan

- SW 0xDEADBEEF to 0x80000010, then LW from the same address. Required: strobes 1111 in ACCESS, then resp_rdata 0xDEADBEEF with no fault.
- SB 0x000000A5 to 0x80000013. Required: strobes 1000, mem_data_out 0xA5A5A5A5. A following LB returns 0xFFFFFFA5 and LBU returns 0x000000A5.
- LH at 0x80000001. Required: resp_valid at N+1, cause 4, and no ACCESS cycle (mem_write_enable stays 0).
- SW to 0x00000100 (read-only) and SW to 0xFFFF0000 (write-only). Required: cause 7 with strobes 0000, and cause 0 with strobes 1111, respectively. LW from 0xFFFF0000 gives cause 5 with rdata 0.
- funct3=3 load. Required: cause 2, fault 1.
- Assert rst_n low mid-ACCESS during SW. Required: strobes drop to 0 asynchronously, no resp_valid, req_ready high after release.
